// File: rtl/frame_1101_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_1101_pkg
// Description : Shared types and constants for the 1101-sync serial link.
//               The package holds the transmitter state encoding, the sync
//               header, the guard length and a header bit lookup helper.
// Revision    : 1.0 - initial release
// ============================================================================
package frame_1101_pkg;

    // Transmitter states, with explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HDR    = 3'd1,
        PAY    = 3'd2,
        GUARD1 = 3'd3,
        GUARD0 = 3'd4
    } state_t;

    // Sync header, sent MSB-first.
    localparam logic [3:0] HEADER     = 4'b1101;

    // Number of zero bits that close every frame.
    localparam int         GUARD_BITS = 2;

    // Line history that forces a stuffed zero. A 1 after this would complete
    // a false header.
    localparam logic [2:0] STUFF_TRIGGER = 3'b110;

    // Header bit idx (0 = first on the line).
    function automatic logic header_bit(input logic [1:0] idx);
        return HEADER[2'd3 - idx];
    endfunction

endpackage
`default_nettype wire

// File: rtl/frame_1101_tx.sv
`default_nettype none
// ============================================================================
// Module      : frame_1101_tx
// Description : Serial frame transmitter for the 1101-sync link. Accepts a
//               DATA_W-bit word on a valid/ready handshake and sends it
//               MSB-first as: 1101 header, zero-stuffed payload, two guard
//               zeros. Stuffing guarantees that 1101 appears on the line only
//               as a header.
// Ports       : clk       - clock
//               rst       - synchronous active-high reset
//               bit_en    - bit-period strobe; all state advances only here
//               in_data   - payload word, captured on accept
//               in_valid  - payload available
//               in_ready  - combinational ready (bit_en and IDLE/GUARD1)
//               tx        - registered serial line, idle low
//               busy      - registered, high from accept to return to IDLE
//               stuff     - registered, high while tx carries a stuffed 0
// Revision    : 1.0 - initial release
// ============================================================================
module frame_1101_tx
    import frame_1101_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              stuff
);

    localparam int c_CNT_W = $clog2(DATA_W + 1);

    state_t              r_state;
    logic [1:0]          r_hdr_idx;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_sreg;
    logic [2:0]          r_hist;
    logic                r_queued;   // word accepted in GUARD1, header pending

    logic                w_accept;
    logic                w_tx_next;
    logic                w_stuff_next;
    logic                w_hist_clear;

    assign in_ready = bit_en && ((r_state == IDLE) || (r_state == GUARD1));
    assign w_accept = in_valid && in_ready;

    // Bit to be driven onto the line at the next bit_en edge.
    always_comb begin
        w_tx_next    = 1'b0;
        w_stuff_next = 1'b0;
        w_hist_clear = 1'b0;
        case (r_state)
            IDLE: begin
                w_tx_next    = w_accept;
                w_hist_clear = !w_accept;
            end
            HDR: begin
                w_tx_next = header_bit(r_hdr_idx);
            end
            PAY: begin
                // The stuff check takes priority over the bit counter, so a
                // payload ending in ...110 still gets its stuffed zero before
                // the guard.
                if (r_hist == STUFF_TRIGGER) begin
                    w_stuff_next = 1'b1;
                end else if (r_cnt != '0) begin
                    w_tx_next = r_sreg[DATA_W-1];
                end
            end
            GUARD0: begin
                // A queued word starts its header straight after the guard.
                w_tx_next    = r_queued;
                w_hist_clear = !r_queued;
            end
            default: begin
                w_tx_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_hdr_idx <= 2'd0;
            r_cnt     <= '0;
            r_sreg    <= '0;
            r_hist    <= 3'b000;
            r_queued  <= 1'b0;
            tx        <= 1'b0;
            busy      <= 1'b0;
            stuff     <= 1'b0;
        end else if (bit_en) begin
            tx     <= w_tx_next;
            stuff  <= w_stuff_next;
            // History covers header, stuffed and guard bits, so the stuff
            // check sees across the header/payload boundary.
            r_hist <= w_hist_clear ? 3'b000 : {r_hist[1:0], w_tx_next};

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sreg    <= in_data;
                        r_hdr_idx <= 2'd1;
                        busy      <= 1'b1;
                        r_state   <= HDR;
                    end else begin
                        busy      <= 1'b0;
                    end
                end
                HDR: begin
                    r_hdr_idx <= r_hdr_idx + 2'd1;
                    if (r_hdr_idx == 2'd3) begin
                        r_cnt   <= c_CNT_W'(DATA_W);
                        r_state <= PAY;
                    end
                end
                PAY: begin
                    if (r_hist != STUFF_TRIGGER) begin
                        if (r_cnt != '0) begin
                            r_sreg <= r_sreg << 1;
                            r_cnt  <= r_cnt - c_CNT_W'(1);
                        end else begin
                            r_state <= GUARD1;
                        end
                    end
                end
                GUARD1: begin
                    r_state <= GUARD0;
                    if (w_accept) begin
                        r_sreg   <= in_data;
                        r_queued <= 1'b1;
                    end
                end
                GUARD0: begin
                    if (r_queued) begin
                        r_queued  <= 1'b0;
                        r_hdr_idx <= 2'd1;
                        r_state   <= HDR;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
